i2c_target: RTL and testbench

I2C target (responder) with an 8-bit register-pointer protocol. It lets on-board I2C masters (PLL configuration, external debug controller) read and write an internal register file. Write transactions set the pointer and then write bytes with auto-increment. Read transactions return bytes from the pointer with auto-increment. The block sits in the peripheral clock domain and connects to open-drain SCL/SDA pads and to a simple one-cycle register strobe interface.

---
 rtl/i2c_target.sv | 159 +++++++++++++++
 tb/tb_i2c_target.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// i2c_target: I2C responder giving I2C masters pointer-based read/write access to a register file.
// Writes load the pointer and then store bytes; reads return bytes from the pointer. Both auto-increment.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_write,
    output logic       reg_read,
    input  logic [7:0] reg_rdata
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     scl_s_q, sda_s_q, cnt_q, cnt_d;
    logic [6:0]     sr_q, sr_d;
    logic [7:0]     tx_q, tx_d, addr_q, addr_d, wdata_q, wdata_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           oe_q, oe_d, busy_q, busy_d, rw_q, rw_d;
    logic           write_q, write_d, read_q, read_d, pend_q, pend_d;
    logic           rise, fall, start, stop, sda_bit, last, ack_exit;
    logic [7:0]     byte_in;

    // Bits [1:0] synchronise the pads; bit 2 is the previous level for edge detection.
    assign rise     = scl_s_q[1] & ~scl_s_q[2];
    assign fall     = ~scl_s_q[1] & scl_s_q[2];
    assign start    = scl_s_q[1] & scl_s_q[2] & sda_s_q[2] & ~sda_s_q[1];
    assign stop     = scl_s_q[1] & scl_s_q[2] & ~sda_s_q[2] & sda_s_q[1];
    assign sda_bit  = sda_s_q[1];
    assign byte_in  = {sr_q, sda_bit};
    assign last     = cnt_q == 3'd7;
    // ACK slots span one extra SCL rise; leave on the fall that follows it.
    assign ack_exit = fall && cnt_q == 3'd1;

    assign sda_oe    = oe_q & ~reset;
    assign busy      = busy_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_write = write_q;
    assign reg_read  = read_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = rise ? cnt_q + 3'd1 : cnt_q;
        sr_d    = rise ? byte_in[6:0] : sr_q;
        tx_d    = read_q ? reg_rdata : tx_q;
        hold_d  = fall ? HW'(HOLD_CYCLES) : (hold_q != '0 ? hold_q - HW'(1) : hold_q);
        oe_d    = oe_q;
        busy_d  = busy_q;
        rw_d    = rw_q;
        addr_d  = write_q ? addr_q + 8'd1 : addr_q;
        wdata_d = wdata_q;
        write_d = 1'b0;
        read_d  = pend_q;
        pend_d  = 1'b0;
        if (hold_q == HW'(1))
            oe_d = (state_q inside {ADDR_ACK, PTR_ACK, WDATA_ACK}) || (state_q == RDATA && !tx_q[7]);
        case (state_q)
            ADDR: if (rise && last) begin
                if (byte_in[7:1] == TARGET_ADDR) begin
                    state_d = ADDR_ACK;
                    busy_d  = 1'b1;
                    rw_d    = byte_in[0];
                    read_d  = byte_in[0];
                end else begin
                    state_d = IGNORE;
                end
            end
            ADDR_ACK: if (ack_exit) begin
                state_d = rw_q ? RDATA : PTR;
                cnt_d   = '0;
            end
            PTR: if (rise && last) begin
                addr_d  = byte_in;
                state_d = PTR_ACK;
            end
            PTR_ACK, WDATA_ACK: if (ack_exit) begin
                state_d = WDATA;
                cnt_d   = '0;
            end
            WDATA: if (rise && last) begin
                write_d = 1'b1;
                wdata_d = byte_in;
                state_d = WDATA_ACK;
            end
            RDATA: begin
                if (fall) tx_d = {tx_q[6:0], 1'b0};
                if (rise && last) state_d = RDATA_ACK;
            end
            RDATA_ACK: begin
                // The pointer advances on NACK as well, so it always ends past the last byte read.
                if (rise) begin
                    addr_d  = addr_q + 8'd1;
                    pend_d  = !sda_bit;
                    state_d = sda_bit ? IGNORE : RDATA_ACK;
                end
                if (ack_exit) begin
                    state_d = RDATA;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
        if (start || stop) begin
            state_d = start ? ADDR : IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            scl_s_q <= 3'b111;
            sda_s_q <= 3'b111;
            cnt_q   <= '0;
            sr_q    <= '0;
            tx_q    <= '0;
            hold_q  <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scl_s_q <= {scl_s_q[1:0], scl_in};
            sda_s_q <= {sda_s_q[1:0], sda_in};
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            tx_q    <= tx_d;
            hold_q  <= hold_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            read_q  <= read_d;
            pend_q  <= pend_d;
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C master with a pointer/register-file reference model and a scoreboard.
module tb_i2c_target;
    logic       clk = 1'b0, reset = 1'b1, scl = 1'b1, m_sda = 1'b1;
    logic       sda_line, sda_oe, busy, reg_write, reg_read;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    i2c_target dut (
        .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe), .busy(busy),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_write(reg_write), .reg_read(reg_read),
        .reg_rdata(reg_rdata)
    );

    always #5 clk = ~clk;
    assign sda_line = m_sda & ~sda_oe;

    logic [7:0] mem [256];
    logic [7:0] mdl_mem [256];
    logic [7:0] ptr_m = 8'h00;
    logic [7:0] wbuf [$];
    bit         inv_mode = 1'b0, quiet = 1'b0;
    int         qviol = 0, errors = 0, checks = 0;
    int         wq [$], rq [$], bqv [$], oq [$];
    string      bqn [$];

    assign reg_rdata = inv_mode ? ~reg_addr : mem[reg_addr];
    always @(posedge clk) if (reg_write) mem[reg_addr] <= reg_wdata;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        int w, o;
        if (quiet && sda_oe) qviol++;
        if (reg_write) begin
            if (wq.size() == 0) chk("write_unexpected", int'(reg_write), 0);
            else begin
                w = wq.pop_front();
                chk("write_addr", reg_addr, w >> 8);
                chk("write_data", reg_wdata, w & 255);
                chk("write_read_overlap", reg_read, 0);
            end
        end
        if (reg_read) begin
            if (rq.size() == 0) chk("read_unexpected", int'(reg_read), 0);
            else chk("read_addr", reg_addr, rq.pop_front());
        end
        if (oq.size() != 0) begin
            o = oq.pop_front();
            if (bqv.size() == 0) chk("bus_unexpected", o, -1);
            else chk(bqn.pop_front(), o, bqv.pop_front());
        end
    end

    task automatic wc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expb(input string n, input int v);
        bqn.push_back(n);
        bqv.push_back(v);
    endtask

    function automatic int val(input logic [7:0] a);
        logic [7:0] r;
        r = inv_mode ? ~a : mdl_mem[a];
        return int'(r);
    endfunction

    task automatic bit_c(input logic b, output logic s);
        wc(14); m_sda = b;
        wc(6);  scl = 1'b1;
        wc(10); s = sda_line;
        wc(10); scl = 1'b0;
    endtask

    task automatic start_c();
        m_sda = 1'b1; wc(20); scl = 1'b1; wc(20); m_sda = 1'b0; wc(20); scl = 1'b0;
    endtask

    task automatic stop_c();
        m_sda = 1'b0; wc(20); scl = 1'b1; wc(20); m_sda = 1'b1; wc(20);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_c(d[i], s);
        bit_c(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_c(1'b1, s);
            d[i] = s;
        end
        bit_c(nack, s);
    endtask

    task automatic tx_write(input logic [6:0] a, input logic [7:0] p, input bit do_stop);
        logic ack;
        bit   m;
        m = (a == 7'h42);
        qviol = 0;
        quiet = !m;
        start_c();
        expb("addr_ack", int'(m));
        write_byte({a, 1'b0}, ack); oq.push_back(int'(ack));
        chk("busy_after_addr", busy, int'(m));
        expb("ptr_ack", int'(m));
        write_byte(p, ack); oq.push_back(int'(ack));
        if (m) ptr_m = p;
        foreach (wbuf[i]) begin
            expb("data_ack", int'(m));
            if (m) begin
                wq.push_back(int'({ptr_m, wbuf[i]}));
                mdl_mem[ptr_m] = wbuf[i];
                ptr_m = ptr_m + 8'd1;
            end
            write_byte(wbuf[i], ack); oq.push_back(int'(ack));
        end
        if (do_stop) begin
            stop_c(); wc(4);
            chk("busy_after_stop", busy, 0);
        end
        if (!m) chk("quiet_sda_oe", qviol, 0);
        quiet = 1'b0;
        chk("ptr_after_write", reg_addr, ptr_m);
    endtask

    task automatic tx_read(input int n);
        logic       ack;
        logic [7:0] p, q, d;
        p = ptr_m;
        start_c();
        rq.push_back(int'(p));
        expb("raddr_ack", 1);
        write_byte({7'h42, 1'b1}, ack); oq.push_back(int'(ack));
        for (int i = 0; i < n; i++) begin
            expb("rdata", val(p));
            q = p + 8'd1;
            if (i < n - 1) rq.push_back(int'(q));
            read_byte(i == n - 1, d); oq.push_back(int'(d));
            wc(1);
            if (i == n - 1) chk("sda_released_after_nack", sda_oe, 0);
            p = q;
        end
        ptr_m = p;
        stop_c(); wc(4);
        chk("busy_after_read", busy, 0);
        chk("ptr_after_read", reg_addr, ptr_m);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        logic s;
        logic [7:0] v;
        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
        wc(3);
        chk("rst_sda_oe", sda_oe, 0); chk("rst_busy", busy, 0); chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_wdata", reg_wdata, 0); chk("rst_reg_write", reg_write, 0); chk("rst_reg_read", reg_read, 0);
        reset = 1'b0;
        wc(5);
        wbuf = '{8'hA5, 8'h5A};
        tx_write(7'h42, 8'h10, 1'b1);
        wbuf = '{};
        tx_write(7'h43, 8'h10, 1'b1);
        inv_mode = 1'b1;
        tx_write(7'h42, 8'hFE, 1'b0);
        tx_read(3);
        inv_mode = 1'b0;
        tx_write(7'h42, 8'h20, 1'b0);
        for (int i = 7; i >= 4; i--) begin
            v = 8'hC3;
            bit_c(v[i], s);
        end
        stop_c(); wc(4);
        chk("busy_after_abort", busy, 0);
        wbuf = '{8'h99};
        tx_write(7'h42, 8'h21, 1'b1);
        wbuf = '{};
        tx_write(7'h42, 8'h33, 1'b1);
        tx_read(1);
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                wbuf = '{};
                repeat ($urandom_range(0, 3)) wbuf.push_back(8'($urandom));
                tx_write(($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h42, 8'($urandom), 1'b1);
            end else begin
                tx_read(int'($urandom_range(1, 3)));
            end
        end
        start_c();
        v = 8'h84;
        for (int i = 7; i >= 0; i--) bit_c(v[i], s);
        for (int i = 0; i < 30 && !sda_oe; i++) wc(1);
        chk("ack_driven_before_reset", sda_oe, 1);
        #3 reset = 1'b1;
        #1 chk("reset_releases_sda", sda_oe, 0);
        m_sda = 1'b1; scl = 1'b1;
        wc(1);
        chk("mid_rst_busy", busy, 0); chk("mid_rst_reg_addr", reg_addr, 0);
        chk("mid_rst_reg_wdata", reg_wdata, 0); chk("mid_rst_strobes", {reg_write, reg_read}, 0);
        wc(3);
        reset = 1'b0;
        ptr_m = 8'h00;
        wc(5);
        wbuf = '{8'h3C};
        tx_write(7'h42, 8'h40, 1'b1);
        wc(10);
        chk("write_queue_drained", wq.size(), 0);
        chk("read_queue_drained", rq.size(), 0);
        chk("bus_queue_drained", bqv.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
